// File: rtl/synchronous_fifo_pkg.sv
// synchronous_fifo_pkg: default widths, thresholds and depth helper shared by the FIFO files
package synchronous_fifo_pkg;
  localparam int default_data_bus_length = 8;
  localparam int default_address_bus_length = 4;
  localparam int default_almost_full_level = 12;
  localparam int default_almost_empty_level = 2;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, one write port and one registered read port on clk
module fifo_mem
  import synchronous_fifo_pkg::*;
#(
  parameter int data_bus_length = default_data_bus_length,
  parameter int address_bus_length = default_address_bus_length
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [address_bus_length-1:0] waddr,
  input  logic [data_bus_length-1:0]    wdata,
  input  logic                          re,
  input  logic [address_bus_length-1:0] raddr,
  output logic [data_bus_length-1:0]    rdata
);
  logic [data_bus_length-1:0] mem [fifo_depth(address_bus_length)];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/synchronous_fifo.sv
// synchronous_fifo: single-clock FIFO with registered flags; SYNCHRONOUS_FIFO_ERR_EN adds sticky overflow/underflow
module synchronous_fifo
  import synchronous_fifo_pkg::*;
#(
  parameter int data_bus_length = default_data_bus_length,
  parameter int address_bus_length = default_address_bus_length,
  parameter int almost_full_level = default_almost_full_level,
  parameter int almost_empty_level = default_almost_empty_level
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_enable,
  input  logic [data_bus_length-1:0]    trans_data,
  input  logic                          read_enable,
  output logic [data_bus_length-1:0]    recv_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          almost_full,
  output logic                          almost_empty,
`ifdef SYNCHRONOUS_FIFO_ERR_EN
  output logic                          overflow,
  output logic                          underflow,
`endif
  output logic [address_bus_length:0]   fill_count
);
  localparam int aw = address_bus_length;
  localparam logic [aw:0] depth_c = (aw+1)'(fifo_depth(aw));
  localparam logic [aw:0] af_c = (aw+1)'(almost_full_level);
  localparam logic [aw:0] ae_c = (aw+1)'(almost_empty_level);
  logic [aw:0] wr_ptr, rd_ptr, cnt_n;
  logic wr_acc, rd_acc;
  // a read frees a slot in the same cycle, so a full FIFO still accepts a paired write
  always_comb begin
    rd_acc = read_enable && !fifo_empty && !rst;
    wr_acc = write_enable && (!fifo_full || rd_acc) && !rst;
    cnt_n = wr_acc && !rd_acc ? fill_count + 1'b1 : rd_acc && !wr_acc ? fill_count - 1'b1 : fill_count;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_count <= '0;
      fifo_full <= 1'b0;
      fifo_empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      fill_count <= cnt_n;
      fifo_full <= cnt_n == depth_c;
      fifo_empty <= cnt_n == '0;
      almost_full <= cnt_n >= af_c;
      almost_empty <= cnt_n <= ae_c;
    end
`ifdef SYNCHRONOUS_FIFO_ERR_EN
  always_ff @(posedge clk)
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && fifo_full && !rd_acc) overflow <= 1'b1;
      if (read_enable && fifo_empty) underflow <= 1'b1;
    end
`endif
  fifo_mem #(.data_bus_length(data_bus_length), .address_bus_length(aw)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr_acc),
    .waddr(wr_ptr[aw-1:0]),
    .wdata(trans_data),
    .re(rd_acc),
    .raddr(rd_ptr[aw-1:0]),
    .rdata(recv_data)
  );
endmodule

// File: tb/tb_synchronous_fifo.sv
// tb_synchronous_fifo: directed self-checking bench for synchronous_fifo at default parameters
module tb_synchronous_fifo;
  logic clk = 1'b0, rst = 1'b1, write_enable = 1'b0, read_enable = 1'b0;
  logic [7:0] trans_data = '0, recv_data;
  logic fifo_full, fifo_empty, almost_full, almost_empty;
  logic [4:0] fill_count;
  int checks = 0, failures = 0;
`ifdef SYNCHRONOUS_FIFO_ERR_EN
  logic overflow, underflow;
`endif
  synchronous_fifo dut (
    .clk(clk),
    .rst(rst),
    .write_enable(write_enable),
    .trans_data(trans_data),
    .read_enable(read_enable),
    .recv_data(recv_data),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
`ifdef SYNCHRONOUS_FIFO_ERR_EN
    .overflow(overflow),
    .underflow(underflow),
`endif
    .fill_count(fill_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step(input logic we, input logic [7:0] d, input logic re);
    write_enable = we;
    trans_data = d;
    read_enable = re;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable = 1'b0;
  endtask
  initial begin
    step(1'b1, 8'd1, 1'b1);
    rst = 1'b0;
    check("rst_fill", 32'(fill_count), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_recv", 32'(recv_data), 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(17 + i), 1'b0);
      if (i == 10) check("afull_at11", 32'(almost_full), 0);
      if (i == 11) check("afull_at12", 32'(almost_full), 1);
    end
    check("fill_16", 32'(fill_count), 16);
    check("full_16", 32'(fifo_full), 1);
    check("empty_16", 32'(fifo_empty), 0);
    step(1'b1, 8'd99, 1'b0);
    check("drop_fill", 32'(fill_count), 16);
    check("drop_full", 32'(fifo_full), 1);
`ifdef SYNCHRONOUS_FIFO_ERR_EN
    check("overflow", 32'(overflow), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'd0, 1'b1);
      check("drain_data", 32'(recv_data), 32'(17 + i));
      if (i == 0) check("drain_full", 32'(fifo_full), 0);
      if (i == 12) check("aempty_at3", 32'(almost_empty), 0);
      if (i == 13) check("aempty_at2", 32'(almost_empty), 1);
    end
    check("drain_fill", 32'(fill_count), 0);
    check("drain_empty", 32'(fifo_empty), 1);
`ifdef SYNCHRONOUS_FIFO_ERR_EN
    check("no_underflow", 32'(underflow), 0);
`endif
    step(1'b1, 8'd5, 1'b1);
    check("erw_fill", 32'(fill_count), 1);
    check("erw_recv", 32'(recv_data), 32);
    check("erw_empty", 32'(fifo_empty), 0);
    step(1'b0, 8'd0, 1'b1);
    check("erw_read", 32'(recv_data), 5);
    check("erw_fill0", 32'(fill_count), 0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(100 + i), 1'b0);
    check("fill_8", 32'(fill_count), 8);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(108 + i), 1'b1);
      check("stream_data", 32'(recv_data), 32'(100 + i));
      check("stream_fill", 32'(fill_count), 8);
    end
    step(1'b1, 8'd200, 1'b0);
    step(1'b1, 8'd201, 1'b0);
    check("fill_10", 32'(fill_count), 10);
    rst = 1'b1;
    step(1'b1, 8'd77, 1'b1);
    rst = 1'b0;
    check("mid_rst_fill", 32'(fill_count), 0);
    check("mid_rst_empty", 32'(fifo_empty), 1);
    check("mid_rst_recv", 32'(recv_data), 0);
`ifdef SYNCHRONOUS_FIFO_ERR_EN
    check("rst_overflow", 32'(overflow), 0);
`endif
    step(1'b0, 8'd0, 1'b1);
    check("empty_rd_fill", 32'(fill_count), 0);
    check("empty_rd_recv", 32'(recv_data), 0);
    check("empty_rd_empty", 32'(fifo_empty), 1);
`ifdef SYNCHRONOUS_FIFO_ERR_EN
    check("underflow", 32'(underflow), 1);
`endif
    step(1'b1, 8'd42, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    check("post_rst_data", 32'(recv_data), 42);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
